neuron_serial: RTL and testbench
================================

# neuron_serial

Parametrised, time-multiplexed successor to the fixed 14-input output neuron. It computes one weighted sum of `N_IN` signed inputs on a single shared multiplier, accumulates at full precision, then maps the result through a sigmoid LUT or an optional linear bypass. A valid/ready handshake sits on both sides, so layers of these neurons chain directly in the network datapath without fixed-latency bookkeeping.

## Interface
- `N_IN`, 14: number of inputs per neuron (≥1).
- `DW`, 17: width of each `x`/`w` element and of `y`.
- `LUT_AW`, 11: sigmoid LUT address width.
- `ACC_SHIFT`, 16: arithmetic right shift applied to the accumulator before the LUT/bypass.
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `ce` in 1: clock enable. While low, all state, counters and outputs hold.
- `in_valid` in 1: operand vector valid.
- `in_ready` out 1: block idle and able to accept.
- `x` in `N_IN*DW`: inputs, two's complement; element i is `x[DW*(i+1)-1:DW*i]`.
- `w` in `N_IN*DW`: weights, same packing.
- `act_bypass` in 1: sampled on accept. 1 selects linear output; 0 selects sigmoid.
- `out_valid` out 1: `y` valid.
- `out_ready` in 1: downstream accepts `y`.
- `y` out `DW`: result. Sigmoid mode: unsigned Q1.16. Bypass mode: signed.

## Operation
- **Accumulator width:** `ACC_W = 2*DW + clog2(N_IN)`. Products are exact signed `2*DW`, sign-extended and summed with no overflow.
- **States:** `IDLE` → `MAC` → `SCALE` → `LUT` → `HOLD` → `IDLE`.
- **IDLE:** `in_ready=1`. On `in_valid & in_ready & ce`:
  - register `x`, `w` and `act_bypass`;
  - clear the accumulator and set the index counter to 0;
  - go to `MAC`.
- **MAC:** one product per cycle, `acc += x[k]*w[k]`, for k = 0..N_IN-1. After the k = N_IN-1 term is added, go to `SCALE`.
- **SCALE:**
  - `s = acc >>> ACC_SHIFT` (arithmetic shift).
  - Sigmoid mode: `idx = clamp(s, -2^(LUT_AW-1), 2^(LUT_AW-1)-1) + 2^(LUT_AW-1)`.
  - Bypass mode: `lin = clamp(s, -2^(DW-1), 2^(DW-1)-1)`.
  - Go to `LUT`.
- **LUT:** one-cycle registered ROM read of `idx`. In bypass mode, `lin` passes through this stage so latency is identical in both modes. Go to `HOLD` with `out_valid=1`.
- **HOLD:** `y` and `out_valid` stay stable until `out_valid & out_ready & ce`, then return to `IDLE`.
- **LUT contents:** entry k = `round(65536 / (1 + exp(-(k - 2^(LUT_AW-1)) / 128)))`, saturated to `2^(DW-1)-1`.
- **Accepted inputs are captured:** `x`, `w` and `act_bypass` may change after the accept cycle without affecting the current result.
- **Single outstanding job:** `in_ready=0` in every state except `IDLE`. No new input is accepted in the cycle `y` is consumed; the next accept is possible the following cycle.

## Timing
- **Reset values:** state `IDLE`, `in_ready=1`, `out_valid=0`, `y=0`, accumulator and counter 0.
- **Reset mid-operation:** reset in any state aborts the job with no output produced. `rst` has priority over `ce`.
- **Latency:** accept at edge T gives `out_valid=1` after edge T+N_IN+2, i.e. N_IN MAC cycles, 1 SCALE cycle and 1 LUT cycle, all counted with `ce=1`.
- **Stalls:** with `ce` low, latency stretches by the number of stalled cycles and no state advances.
- **Throughput:** one result per N_IN+4 cycles when `out_ready` is held high.
- **Backpressure:** `out_ready` low keeps the block in `HOLD` indefinitely with `y` unchanged.

## Structure
- **Package `neuron_pkg`:** defaults for `DW`, `LUT_AW` and `ACC_SHIFT`; the sigmoid scale constant (128); the state enum; a `clamp` function used for both the LUT index and the bypass value.
- **Sub-module `sigma_lut`:** parametrised by `LUT_AW` and `DW`; registered synchronous ROM with a `ce` input; contents generated from the formula in Operation.
- **Top level:** state machine, operand registers, counter, multiplier and accumulator.

## Test plan
All scenarios use default parameters unless stated.

- **Zero input:** all `x=0`, sigmoid mode → `y=32768` (0x08000), `out_valid` at exactly T+16.
- **Single term:** `x0=256`, `w0=256`, others 0 → acc=65536, idx=1025, `y=LUT[1025]=32896`. With `act_bypass=1` → `y=1`.
- **Saturation, sign and width:**
  - all `x=w=-65536` → acc=14·2^32, clamps to idx=2047, `y=LUT[2047]`;
  - `x=-65536`, `w=65535` for all → idx=0;
  - in bypass mode, the same two vectors give `y=65535` and `y=-65536`.
- **Backpressure and capture:**
  - hold `out_ready=0` for 20 cycles: `y` stable, `in_ready=0`, `in_valid` ignored;
  - change `x` the cycle after accept: result unchanged.
- **Stall and reset:**
  - toggle `ce` every cycle during MAC: result equals the unstalled result, latency doubles;
  - assert `rst` in MAC: `out_valid` never rises, `in_ready=1` the next cycle.
- **Parameter sweep:** `N_IN=1` and `N_IN=32` with random vectors: results match a software model; latency is N_IN+2 cycles.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared defaults, FSM state type and the saturating clamp used by the neuron.
package neuron_pkg;

    localparam int unsigned DefDw       = 17;
    localparam int unsigned DefLutAw    = 11;
    localparam int unsigned DefAccShift = 16;
    // Sigmoid input scale: LUT step k covers an argument step of 1/SigScale.
    localparam int unsigned SigScale    = 128;

    typedef enum logic [2:0] {
        StIdle,
        StMac,
        StScale,
        StLut,
        StHold
    } state_e;

    // Saturate v into [lo, hi]; used for both the LUT index and the linear output.
    function automatic logic signed [63:0] clamp(input logic signed [63:0] v,
                                                 input logic signed [63:0] lo,
                                                 input logic signed [63:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/sigma_lut.sv
// Registered sigmoid ROM. Entry k = round(65536 / (1 + exp(-(k - Half) / SigScale))),
// saturated to the largest positive DW-bit value. Contents are built at elaboration
// with 64-bit fixed-point arithmetic so no file loading or real math is needed.
module sigma_lut
    import neuron_pkg::*;
#(
    parameter int unsigned LUT_AW = DefLutAw,
    parameter int unsigned DW     = DefDw
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ce_i,
    input  logic [LUT_AW-1:0] addr_i,
    output logic [DW-1:0]     data_o
);

    localparam int unsigned Depth = 2 ** LUT_AW;
    localparam longint      Half  = longint'(1) <<< (LUT_AW - 1);
    localparam longint      YMax  = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint      One   = longint'(1) <<< 31;  // 1.0 in Q31

    // exp(-a / SigScale) in Q31: series for the unit step, then square-and-multiply.
    function automatic longint exp_neg(input longint a);
        longint step;
        longint term;
        longint res;
        longint base;
        step = 0;
        term = One;
        for (int i = 0; i < 12; i++) begin
            step = (i % 2 == 0) ? step + term : step - term;
            term = term / (longint'(SigScale) * longint'(i + 1));
        end
        res  = One;
        base = step;
        for (int b = 0; b < 32; b++) begin
            if (((a >>> b) & 1) != 0) res = (res * base) >>> 31;
            base = (base * base) >>> 31;
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] sig_entry(input int k);
        longint d;
        longint p;
        longint f;
        longint v;
        d = longint'(k) - Half;
        p = exp_neg((d < 0) ? -d : d);
        // 65536 / (1 + p) with 8 guard bits; negative side uses 1 - sigmoid(|t|).
        f = (longint'(1) <<< 55) / (One + p);
        if (d < 0) f = (longint'(1) <<< 24) - f;
        v = (f + 128) >>> 8;
        if (v > YMax) v = YMax;
        return DW'(v);
    endfunction

    logic [DW-1:0] rom [Depth];

    for (genvar k = 0; k < Depth; k++) begin : g_rom
        localparam logic [DW-1:0] Entry = sig_entry(k);
        assign rom[k] = Entry;
    end

    logic [DW-1:0] data_q;

    // One-cycle synchronous read, held while ce_i is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (ce_i) begin
            data_q <= rom[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/neuron_serial.sv
// Time-multiplexed neuron: one shared multiplier walks N_IN products into a
// full-precision accumulator, then the scaled sum goes through a sigmoid LUT or
// a saturating linear bypass. Valid/ready on both sides, one job in flight.
module neuron_serial
    import neuron_pkg::*;
#(
    parameter int unsigned N_IN      = 14,
    parameter int unsigned DW        = DefDw,
    parameter int unsigned LUT_AW    = DefLutAw,
    parameter int unsigned ACC_SHIFT = DefAccShift
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ce_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [N_IN*DW-1:0] x_i,
    input  logic [N_IN*DW-1:0] w_i,
    input  logic               act_bypass_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DW-1:0]      y_o
);

    localparam int unsigned AccW = 2 * DW + $clog2(N_IN);
    localparam int unsigned CntW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic signed [63:0] LutHalf = 64'sd1 <<< (LUT_AW - 1);
    localparam logic signed [63:0] YHalf   = 64'sd1 <<< (DW - 1);

    state_e                 state_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [N_IN*DW-1:0]     x_q;
    logic [N_IN*DW-1:0]     w_q;
    logic                   byp_q;
    logic [CntW-1:0]        cnt_q;
    logic signed [AccW-1:0] acc_q;
    logic [LUT_AW-1:0]      idx_q;
    logic [DW-1:0]          lin_q;

    logic signed [2*DW-1:0] prod;
    logic signed [63:0]     s64;
    logic [LUT_AW-1:0]      idx_d;
    logic [DW-1:0]          lin_d;
    logic                   lut_en;
    logic [DW-1:0]          lut_y;

    // Operand registers shift down one element per MAC cycle, so element 0 is always current.
    assign prod = $signed(x_q[DW-1:0]) * $signed(w_q[DW-1:0]);

    // Scale the sum and saturate it for both the LUT index and the linear result.
    always_comb begin
        s64   = 64'(acc_q >>> ACC_SHIFT);
        idx_d = LUT_AW'(clamp(s64, -LutHalf, LutHalf - 64'sd1) + LutHalf);
        lin_d = DW'(clamp(s64, -YHalf, YHalf - 64'sd1));
    end

    // Control FSM with operand capture, MAC and scale registers; rst wins over ce.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            w_q         <= '0;
            byp_q       <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            lin_q       <= '0;
        end else if (ce_i) begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        x_q        <= x_i;
                        w_q        <= w_i;
                        byp_q      <= act_bypass_i;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + AccW'(prod);
                    x_q   <= x_q >> DW;
                    w_q   <= w_q >> DW;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(N_IN - 1)) state_q <= StScale;
                end
                StScale: begin
                    idx_q   <= idx_d;
                    lin_q   <= lin_d;
                    state_q <= StLut;
                end
                StLut: begin
                    out_valid_q <= 1'b1;
                    state_q     <= StHold;
                end
                StHold: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign lut_en = ce_i && (state_q == StLut);

    sigma_lut #(
        .LUT_AW(LUT_AW),
        .DW    (DW)
    ) u_lut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ce_i  (lut_en),
        .addr_i(idx_q),
        .data_o(lut_y)
    );

    // lin_q is only rewritten in SCALE, so it stays stable through LUT and HOLD.
    assign y_o         = byp_q ? lin_q : lut_y;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_neuron_serial.sv
// Directed bench for neuron_serial: default 14-input instance plus N_IN=1 and N_IN=32.
module tb_neuron_serial;

    localparam int DW = 17;

    logic clk = 1'b0;
    logic rst;
    logic ce;
    always #5 clk = ~clk;

    logic iv, ir, ov, ordy, byp;
    logic [14*DW-1:0] x, w;
    logic [DW-1:0] y;

    logic a_iv, a_ir, a_ov, a_byp;
    logic [DW-1:0] a_x, a_w, a_y;

    logic b_iv, b_ir, b_ov, b_byp;
    logic [32*DW-1:0] b_x, b_w;
    logic [DW-1:0] b_y;

    int n_chk = 0;
    int n_fail = 0;
    int sx[32];
    int sw[32];

    neuron_serial #(.N_IN(14)) dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(iv), .in_ready_o(ir),
        .x_i(x), .w_i(w), .act_bypass_i(byp), .out_valid_o(ov), .out_ready_i(ordy), .y_o(y)
    );

    neuron_serial #(.N_IN(1)) dut_n1 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(a_iv), .in_ready_o(a_ir),
        .x_i(a_x), .w_i(a_w), .act_bypass_i(a_byp), .out_valid_o(a_ov), .out_ready_i(1'b1),
        .y_o(a_y)
    );

    neuron_serial #(.N_IN(32)) dut_n32 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(b_iv), .in_ready_o(b_ir),
        .x_i(b_x), .w_i(b_w), .act_bypass_i(b_byp), .out_valid_o(b_ov), .out_ready_i(1'b1),
        .y_o(b_y)
    );

    task automatic fill(input int xv, input int wv);
        for (int i = 0; i < 14; i++) begin
            x[DW*i +: DW] = DW'(xv);
            w[DW*i +: DW] = DW'(wv);
        end
    endtask

    // Accept one job on the 14-input DUT, wait (bounded) for the result, then consume it.
    task automatic do_job(input bit bv, output logic [DW-1:0] yv, output int lat);
        iv = 1'b1;
        byp = bv;
        @(posedge clk); #1;
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 200) begin @(posedge clk); #1; lat++; end
        yv = y;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; iv = 1'b0; ordy = 1'b1; byp = 1'b0; fill(0, 0);
        a_iv = 1'b0; b_iv = 1'b0; a_byp = 1'b0; b_byp = 1'b0; a_x = '0; a_w = '0;
        b_x = '0; b_w = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_chk++; if (ir !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", ir); end
        n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ov); end
        n_chk++; if (y !== '0) begin n_fail++; $display("FAIL reset_y: got %0d expected 0", y); end
    endtask

    task automatic test_zero();
        logic [DW-1:0] yv; int lat;
        fill(0, 0);
        do_job(1'b0, yv, lat);
        n_chk++; if (yv !== 17'd32768) begin n_fail++; $display("FAIL zero_y: got %0d expected 32768", yv); end
        n_chk++; if (lat != 16) begin n_fail++; $display("FAIL zero_latency: got %0d expected 16", lat); end
    endtask

    task automatic test_single_term();
        logic [DW-1:0] yv; int lat;
        fill(0, 0);
        x[DW-1:0] = 17'd256;
        w[DW-1:0] = 17'd256;
        do_job(1'b0, yv, lat);
        n_chk++; if (yv !== 17'd32896) begin n_fail++; $display("FAIL single_sigmoid: got %0d expected 32896", yv); end
        do_job(1'b1, yv, lat);
        n_chk++; if (yv !== 17'd1) begin n_fail++; $display("FAIL single_bypass: got %0d expected 1", yv); end
    endtask

    task automatic test_saturation();
        logic [DW-1:0] yv; int lat;
        fill(-65536, -65536);
        do_job(1'b0, yv, lat);
        n_chk++; if (yv !== 17'd65514) begin n_fail++; $display("FAIL sat_pos_sigmoid: got %0d expected 65514", yv); end
        do_job(1'b1, yv, lat);
        n_chk++; if (yv !== 17'd65535) begin n_fail++; $display("FAIL sat_pos_bypass: got %0d expected 65535", yv); end
        fill(-65536, 65535);
        do_job(1'b0, yv, lat);
        n_chk++; if (yv !== 17'd22) begin n_fail++; $display("FAIL sat_neg_sigmoid: got %0d expected 22", yv); end
        do_job(1'b1, yv, lat);
        n_chk++; if (yv !== 17'h10000) begin n_fail++; $display("FAIL sat_neg_bypass: got %h expected 10000", yv); end
    endtask

    task automatic test_capture();
        int lat;
        fill(0, 0);
        x[DW-1:0] = 17'd512;
        w[DW-1:0] = 17'd256;
        iv = 1'b1; byp = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0; byp = 1'b0;
        fill(-65536, -65536);
        lat = 0;
        while (!ov && lat < 200) begin @(posedge clk); #1; lat++; end
        n_chk++; if (y !== 17'd2) begin n_fail++; $display("FAIL capture_y: got %0d expected 2", y); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat; int bad_y; int bad_ir; int bad_ov; int late_ov;
        bad_y = 0; bad_ir = 0; bad_ov = 0; late_ov = 0;
        fill(0, 0);
        x[DW-1:0] = 17'd256;
        w[DW-1:0] = 17'd256;
        ordy = 1'b0; iv = 1'b1; byp = 1'b0;
        @(posedge clk); #1;
        fill(1000, 1000);
        lat = 0;
        while (!ov && lat < 200) begin @(posedge clk); #1; lat++; end
        for (int c = 0; c < 20; c++) begin
            if (y !== 17'd32896) bad_y++;
            if (ir !== 1'b0) bad_ir++;
            if (ov !== 1'b1) bad_ov++;
            @(posedge clk); #1;
        end
        n_chk++; if (bad_y != 0) begin n_fail++; $display("FAIL bp_y_stable: got %0d bad cycles expected 0", bad_y); end
        n_chk++; if (bad_ir != 0) begin n_fail++; $display("FAIL bp_in_ready_low: got %0d bad cycles expected 0", bad_ir); end
        n_chk++; if (bad_ov != 0) begin n_fail++; $display("FAIL bp_out_valid_held: got %0d bad cycles expected 0", bad_ov); end
        iv = 1'b0; ordy = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (ir !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b expected 1", ir); end
        for (int c = 0; c < 20; c++) begin
            if (ov === 1'b1) late_ov++;
            @(posedge clk); #1;
        end
        n_chk++; if (late_ov != 0) begin n_fail++; $display("FAIL bp_no_ghost_job: got %0d valid cycles expected 0", late_ov); end
    endtask

    task automatic test_stall();
        logic [DW-1:0] yv; int lat;
        fill(256, 256);
        do_job(1'b1, yv, lat);
        n_chk++; if (yv !== 17'd14) begin n_fail++; $display("FAIL nostall_y: got %0d expected 14", yv); end
        iv = 1'b1; byp = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0; ce = 1'b0;
        lat = 0;
        while (!ov && lat < 200) begin @(posedge clk); #1; lat++; ce = ~ce; end
        ce = 1'b1;
        n_chk++; if (y !== 17'd14) begin n_fail++; $display("FAIL stall_y: got %0d expected 14", y); end
        n_chk++; if (lat != 32) begin n_fail++; $display("FAIL stall_latency: got %0d expected 32", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] yv; int lat; int late_ov;
        late_ov = 0;
        fill(256, 256);
        iv = 1'b1; byp = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; ce = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; ce = 1'b1;
        n_chk++; if (ir !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", ir); end
        for (int c = 0; c < 30; c++) begin
            if (ov === 1'b1) late_ov++;
            @(posedge clk); #1;
        end
        n_chk++; if (late_ov != 0) begin n_fail++; $display("FAIL rstmid_no_output: got %0d valid cycles expected 0", late_ov); end
        do_job(1'b1, yv, lat);
        n_chk++; if (yv !== 17'd14) begin n_fail++; $display("FAIL rstmid_recover_y: got %0d expected 14", yv); end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$]; int bad_y; int n_ov;
        bad_y = 0; n_ov = 0;
        fill(0, 0);
        x[DW-1:0] = 17'd256;
        w[DW-1:0] = 17'd256;
        iv = 1'b1; byp = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (ir === 1'b1) acc_cyc.push_back(c);
            if (ov === 1'b1) begin n_ov++; if (y !== 17'd1) bad_y++; end
            @(posedge clk); #1;
        end
        iv = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        n_chk++; if (acc_cyc.size() != 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 4", acc_cyc.size()); end
        n_chk++;
        if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] != 18) begin
            n_fail++; $display("FAIL b2b_period: got %0d expected 18",
                               (acc_cyc.size() < 2) ? -1 : acc_cyc[1] - acc_cyc[0]);
        end
        n_chk++; if (n_ov != 3 || bad_y != 0) begin n_fail++; $display("FAIL b2b_results: got %0d valid, %0d bad expected 3 valid, 0 bad", n_ov, bad_y); end
    endtask

    function automatic logic [DW-1:0] model(input int n, input bit bv);
        longint acc; longint s; real r;
        acc = 0;
        for (int i = 0; i < n; i++) acc += longint'(sx[i]) * longint'(sw[i]);
        s = acc >>> 16;
        if (bv) begin
            if (s > 65535) s = 65535;
            if (s < -65536) s = -65536;
            return DW'(s);
        end
        if (s > 1023) s = 1023;
        if (s < -1024) s = -1024;
        r = 65536.0 / (1.0 + $exp(-real'(s) / 128.0));
        return DW'($rtoi(r + 0.5));
    endfunction

    task automatic sweep_job(input int n, input bit bv, output logic [DW-1:0] yv, output int lat);
        a_x = DW'(sx[0]);
        a_w = DW'(sw[0]);
        for (int i = 0; i < 32; i++) begin
            b_x[DW*i +: DW] = DW'(sx[i]);
            b_w[DW*i +: DW] = DW'(sw[i]);
        end
        a_byp = bv; b_byp = bv;
        if (n == 1) a_iv = 1'b1; else b_iv = 1'b1;
        @(posedge clk); #1;
        a_iv = 1'b0; b_iv = 1'b0;
        lat = 0;
        while (!((n == 1) ? a_ov : b_ov) && lat < 200) begin @(posedge clk); #1; lat++; end
        yv = (n == 1) ? a_y : b_y;
        @(posedge clk); #1;
    endtask

    task automatic test_param_sweep();
        logic [DW-1:0] yv; logic [DW-1:0] exp_y; int lat; bit bv; int n;
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? 1 : 32;
            for (int j = 0; j < 8; j++) begin
                for (int i = 0; i < 32; i++) begin
                    if (j % 2 == 0) begin
                        sx[i] = int'($urandom_range(0, 4095)) - 2048;
                        sw[i] = int'($urandom_range(0, 4095)) - 2048;
                    end else begin
                        sx[i] = int'($urandom_range(0, 131071)) - 65536;
                        sw[i] = int'($urandom_range(0, 131071)) - 65536;
                    end
                end
                bv = j[1];
                exp_y = model(n, bv);
                sweep_job(n, bv, yv, lat);
                n_chk++; if (yv !== exp_y) begin n_fail++; $display("FAIL sweep_y n=%0d job=%0d: got %0d expected %0d", n, j, yv, exp_y); end
                n_chk++; if (lat != n + 2) begin n_fail++; $display("FAIL sweep_latency n=%0d job=%0d: got %0d expected %0d", n, j, lat, n + 2); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single_term();
        test_saturation();
        test_capture();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
